// File: rtl/shift164_pkg.sv
// Shared types and constants for the 74LS164 chain controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift164_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETUP,
        HIGH,
        DONE
    } state_t;

    // Width of the half-period / clear-length down-counter (values 0..255).
    localparam int DIV_W = $clog2(256);

    // The chain always ties DSB high so DSA alone carries the data.
    localparam logic SR_DSB_LEVEL = 1'b1;

    // Bit counter must hold 8*num_dev down to 0.
    function automatic int bit_cnt_w(input int num_dev);
        return $clog2(8 * num_dev + 1);
    endfunction

endpackage

// File: rtl/shift164_half_timer.sv
// Loadable down-counter; expire strobes in the cycle the count sits at zero while run is high.
// Latency: expire fires load_val+1 cycles after the load edge (load load_val = N-1 for an N-cycle phase).
// Backpressure: none; load always wins over counting.
// Ports: clk, rst (sync, active high), load/load_val (restart), run (phase active), expire (end of phase).
module shift164_half_timer
    import shift164_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             run,
    output logic             expire
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/shift164_ctrl.sv
// Serialises a parallel frame MSB-first into a 74LS164 chain, generating shift clock and master reset.
// Latency: handshake in cycle 0, done pulse in cycle 16*NUM_DEV*CLK_DIV+1 (+CLR_CYCLES with auto-clear).
// Backpressure: din_ready only in IDLE with no clr_req; din_valid/clr_req ignored while busy.
// Ports: clk/rst (sync, active high); din/din_valid/din_ready frame handshake; clr_req chain clear;
//        busy/done status; sr_cp/sr_dsa/sr_dsb/sr_mr_n drive the chain.
// Build option: define SHIFT164_AUTO_CLR_EN to clear the chain before every frame.
module shift164_ctrl
    import shift164_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int NUM_DEV    = 1,
    parameter int CLR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_DEV-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 clr_req,
    output logic                 busy,
    output logic                 done,
    output logic                 sr_cp,
    output logic                 sr_dsa,
    output logic                 sr_dsb,
    output logic                 sr_mr_n
);

    localparam int W   = 8 * NUM_DEV;
    localparam int BCW = bit_cnt_w(NUM_DEV);

    localparam logic [DIV_W-1:0] HALF_LD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] CLR_LD  = DIV_W'(CLR_CYCLES - 1);

    state_t         state, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [BCW-1:0] bit_cnt, bit_cnt_d;
    logic           cp_d, dsa_d, mr_n_d;
    logic           tmr_load, tmr_run, tmr_expire;
    logic [DIV_W-1:0] tmr_val;
`ifdef SHIFT164_AUTO_CLR_EN
    // Set when CLEAR was entered on behalf of an accepted frame.
    logic           pend, pend_d;
`endif

    assign din_ready = (state == IDLE) && !clr_req;
    assign sr_dsb    = SR_DSB_LEVEL;
    assign tmr_run   = (state == SETUP) || (state == HIGH) || (state == CLEAR);

    shift164_half_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .expire   (tmr_expire)
    );

    // Outputs are computed for the next state and registered alongside it,
    // so sr_cp rises exactly on HIGH entry with sr_dsa already settled.
    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt;
        cp_d      = 1'b0;
        dsa_d     = 1'b0;
        mr_n_d    = 1'b1;
        tmr_load  = 1'b0;
        tmr_val   = HALF_LD;
`ifdef SHIFT164_AUTO_CLR_EN
        pend_d    = pend;
`endif
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_d  = CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LD;
                    mr_n_d   = 1'b0;
                end else if (din_valid) begin
                    shift_d   = din;
                    bit_cnt_d = BCW'(W);
                    tmr_load  = 1'b1;
`ifdef SHIFT164_AUTO_CLR_EN
                    state_d   = CLEAR;
                    tmr_val   = CLR_LD;
                    mr_n_d    = 1'b0;
                    pend_d    = 1'b1;
`else
                    state_d   = SETUP;
                    dsa_d     = din[W-1];
`endif
                end
            end
            CLEAR: begin
                mr_n_d = 1'b0;
                if (tmr_expire) begin
                    mr_n_d  = 1'b1;
                    state_d = IDLE;
`ifdef SHIFT164_AUTO_CLR_EN
                    if (pend) begin
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        dsa_d    = shift_q[W-1];
                        pend_d   = 1'b0;
                    end
`endif
                end
            end
            SETUP: begin
                dsa_d = shift_q[W-1];
                if (tmr_expire) begin
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    cp_d     = 1'b1;
                end
            end
            HIGH: begin
                cp_d  = 1'b1;
                dsa_d = shift_q[W-1];
                if (tmr_expire) begin
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt - 1'b1;
                    cp_d      = 1'b0;
                    if (bit_cnt == BCW'(1)) begin
                        state_d = DONE;
                        dsa_d   = 1'b0;
                    end else begin
                        // Next bit is the one just below the current MSB.
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        dsa_d    = shift_q[W-2];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            sr_cp   <= 1'b0;
            sr_dsa  <= 1'b0;
            sr_mr_n <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SHIFT164_AUTO_CLR_EN
            pend    <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            shift_q <= shift_d;
            bit_cnt <= bit_cnt_d;
            sr_cp   <= cp_d;
            sr_dsa  <= dsa_d;
            sr_mr_n <= mr_n_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
`ifdef SHIFT164_AUTO_CLR_EN
            pend    <= pend_d;
`endif
        end
    end

endmodule

// File: doc/shift164_ctrl.md
Name: shift164_ctrl

Overview:
- Sequencing controller for a chain of 8-bit serial-in/parallel-out shift registers of the 74LS164 type. These are used as display segment/digit drivers in the digital clock design.
- Accepts a parallel frame over a valid/ready handshake and serialises it MSB-first onto the chain's data input.
- Generates the chain's shift clock at a programmable rate and drives the chain's active-low master reset for clear requests.
- Sits between the clock/display logic and the external or IP-modelled 164 chain.

Parameters:
- CLK_DIV, 4: system clock cycles per shift-clock half-period; legal range 1..255.
- NUM_DEV, 1: number of cascaded 8-bit registers (Q7 of device k feeds DSA of device k+1); legal range 1..8.
- CLR_CYCLES, 2: system clock cycles that sr_mr_n is held low for a clear; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  8*NUM_DEV  frame data; bit [8*NUM_DEV-1] is shifted first.
- din_valid  in  1  frame offered.
- din_ready  out  1  controller can accept a frame this cycle.
- clr_req  in  1  request to clear the whole chain.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame has been fully shifted.
- sr_cp  out  1  shift clock to the chain; data is shifted on its rising edge.
- sr_dsa  out  1  serial data to the chain.
- sr_dsb  out  1  second serial data input; held constant 1.
- sr_mr_n  out  1  active-low master reset to the chain.

Behaviour:
- Reset (rst high at a clk edge):
  - sr_cp=0, sr_dsa=0, sr_dsb=1, sr_mr_n=0, busy=0, done=0.
  - State goes to IDLE. The chain is therefore cleared for as long as rst is held.
  - First cycle after rst deasserts: sr_mr_n=1.
- All outputs are registered. The one exception is din_ready = (state==IDLE) && !clr_req.
- States:
  - IDLE
    - clr_req=1 -> CLEAR. clr_req has priority over din_valid; the frame is not accepted.
    - else din_valid=1 -> capture din into the shift buffer, bit counter := 8*NUM_DEV, go to SETUP.
  - SETUP
    - sr_cp=0; sr_dsa = current buffer MSB.
    - Lasts CLK_DIV cycles, then go to HIGH.
  - HIGH
    - sr_cp=1; sr_dsa unchanged. The rising edge occurs on entry, with data stable for the full CLK_DIV-cycle setup.
    - Lasts CLK_DIV cycles.
    - On exit: buffer shifts left by 1 and the counter decrements.
    - Counter reaches 0 -> DONE, else -> SETUP.
  - DONE
    - One cycle: sr_cp=0, done=1.
    - Next state IDLE.
  - CLEAR
    - sr_mr_n=0 for CLR_CYCLES cycles, sr_cp=0.
    - Then IDLE. No done pulse.
- Frame latency:
  - Handshake cycle = cycle 0.
  - Frame occupies cycles 1..16*NUM_DEV*CLK_DIV.
  - done is asserted in cycle 16*NUM_DEV*CLK_DIV+1.
  - din_ready is asserted again the cycle after done.
- Final chain contents: device j Q7..Q0 = din[8j+7 : 8j]. The last device in the chain holds the top byte.
- Inputs ignored while busy:
  - clr_req is ignored, not latched.
  - din_valid is ignored; din_ready is 0.
  - din may change after the handshake without effect.
- sr_dsa is 0 in IDLE, CLEAR and DONE.
- Mid-frame rst: abort immediately and apply the reset values. sr_mr_n=0 clears the partial frame; no done pulse.
- Back-to-back frames: valid held high is accepted in the IDLE cycle after DONE. Minimum frame spacing is 16*NUM_DEV*CLK_DIV+2 cycles.

Optional Feature:
- Macro: SHIFT164_AUTO_CLR_EN.
- With the macro defined:
  - An accepted frame goes IDLE -> CLEAR -> SETUP, with sr_mr_n low for CLR_CYCLES before the first bit.
  - done latency grows by CLR_CYCLES.
  - Explicit clr_req still goes to CLEAR -> IDLE.
- Without the macro: a frame goes IDLE -> SETUP directly, as above.

Decomposition:
- Package shift164_pkg:
  - state enum {IDLE, CLEAR, SETUP, HIGH, DONE};
  - DIV_W = $clog2(256) for the half-period counter;
  - a function returning the bit-counter width, $clog2(8*NUM_DEV+1);
  - constant SR_DSB_LEVEL = 1.
- Sub-module shift164_half_timer:
  - loadable down-counter producing a one-cycle expiry strobe after CLK_DIV or CLR_CYCLES cycles;
  - reused by SETUP, HIGH and CLEAR.

Test Plan:
- CLK_DIV=2, NUM_DEV=1, din=8'hA5 pulse valid:
  - sr_dsa per bit is 1,0,1,0,0,1,0,1;
  - exactly 8 sr_cp rising edges;
  - done in cycle 33;
  - a behavioural 164 model reads Q7..Q0=8'hA5.
- NUM_DEV=2, din=16'h3C81:
  - 16 rising edges;
  - model device1=8'h3C, device0=8'h81;
  - done in cycle 65.
- clr_req and din_valid high together in IDLE:
  - din_ready=0;
  - sr_mr_n low for exactly 2 cycles;
  - frame accepted the first IDLE cycle afterwards.
- clr_req and new din_valid pulsed mid-frame: both ignored; frame completes with the original data.
- rst asserted after the 3rd rising edge:
  - next cycle sr_cp=0, sr_mr_n=0, busy=0, no done;
  - after release, din_ready=1.
- With SHIFT164_AUTO_CLR_EN, CLK_DIV=1, din=8'hFF:
  - sr_mr_n low cycles 1-2;
  - first sr_cp rise in cycle 4;
  - done in cycle 19.
